mem_stage: RTL and testbench

- MEM stage of the 5-stage RV32 pipeline: load/store unit plus the MEM/WB pipeline register that feeds the write-back stage.
- Receives EX/MEM results and runs a registered req/ack transaction to data memory.
- Aligns and sign-extends load data, builds store byte enables, and stalls upstream while a transaction is outstanding.
- Outputs map 1:1 onto write-back inputs (ALU data, memory data, MemToReg, RegWrite, Rd).

---
 rtl/mem_stage.sv | 170 +++++++++++++++++
 tb/tb_mem_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM stage of the RV32 pipeline: registered req/ack load/store unit and the MEM/WB register.
// Stalls upstream while a data-memory transaction is outstanding; ALU ops pass in one cycle.
module mem_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  input  logic                  i_flush,
  input  logic [DATA_WIDTH-1:0] i_ALU_Result,
  input  logic [DATA_WIDTH-1:0] i_Store_Data,
  input  logic [2:0]            i_Funct3,
  input  logic                  i_ctrl_MemRead,
  input  logic                  i_ctrl_MemWrite,
  input  logic                  i_ctrl_MemToReg,
  input  logic                  i_ctrl_RegWrite,
  input  logic [4:0]            i_Rd,
  output logic                  o_stall,
  output logic                  o_mem_fault,
  output logic                  o_dmem_req,
  output logic                  o_dmem_we,
  output logic [ADDR_WIDTH-1:0] o_dmem_addr,
  output logic [DATA_WIDTH-1:0] o_dmem_wdata,
  output logic [3:0]            o_dmem_be,
  input  logic                  i_dmem_ack,
  input  logic [DATA_WIDTH-1:0] i_dmem_rdata,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_ALU_Data,
  output logic [DATA_WIDTH-1:0] o_Mem_Data,
  output logic                  o_ctrl_MemToReg,
  output logic                  o_ctrl_RegWrite,
  output logic [4:0]            o_Rd
);

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nxt;

  logic                  is_mem, legal, aligned, live, mem_op, fault;
  logic [1:0]            off;
  logic [DATA_WIDTH-1:0] st_wdata;
  logic [3:0]            st_be;
  logic [2:0]            f3_q;
  logic [1:0]            off_q;
  logic                  kill_q;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_data;

  assign off    = i_ALU_Result[1:0];
  assign is_mem = i_ctrl_MemRead | i_ctrl_MemWrite;
  assign live   = i_valid & ~i_flush;
  assign legal  = i_ctrl_MemWrite ? (i_Funct3 inside {3'd0, 3'd1, 3'd2})
                                  : (i_Funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
  assign aligned = (i_Funct3[1:0] == 2'b01) ? ~off[0] :
                   (i_Funct3[1:0] == 2'b10) ? (off == 2'b00) : 1'b1;
  assign mem_op = live & is_mem & aligned & legal;
  assign fault  = live & is_mem & ~(aligned & legal);

  always_comb begin
    st_wdata = i_Store_Data;
    st_be    = 4'b1111;
    case (i_Funct3[1:0])
      2'b00: begin
        st_wdata = {4{i_Store_Data[7:0]}};
        st_be    = 4'b0001 << off;
      end
      2'b01: begin
        st_wdata = {2{i_Store_Data[15:0]}};
        st_be    = 4'b0011 << off;
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = i_dmem_rdata[{off_q, 3'b000} +: 8];
    ld_half = off_q[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
    case (f3_q)
      3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_data = {24'd0, ld_byte};
      3'd5:    ld_data = {16'd0, ld_half};
      default: ld_data = i_dmem_rdata;
    endcase
    if (o_dmem_we) ld_data = '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    o_stall   = 1'b0;
    case (state)
      IDLE: begin
        o_stall = mem_op;
        if (mem_op) state_nxt = BUSY;
      end
      BUSY: begin
        o_stall = ~i_dmem_ack;
        if (i_dmem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request side: launch fields stay frozen for the whole BUSY period.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_dmem_req   <= 1'b0;
      o_dmem_we    <= 1'b0;
      o_dmem_addr  <= '0;
      o_dmem_wdata <= '0;
      o_dmem_be    <= '0;
      f3_q         <= '0;
      off_q        <= '0;
      kill_q       <= 1'b0;
      o_mem_fault  <= 1'b0;
    end else begin
      o_mem_fault <= (state == IDLE) & fault;
      if (state == IDLE) begin
        kill_q <= 1'b0;
        if (mem_op) begin
          o_dmem_req   <= 1'b1;
          o_dmem_we    <= i_ctrl_MemWrite;
          o_dmem_addr  <= {i_ALU_Result[ADDR_WIDTH-1:2], 2'b00};
          o_dmem_wdata <= st_wdata;
          o_dmem_be    <= st_be;
          f3_q         <= i_Funct3;
          off_q        <= off;
        end
      end else begin
        // A flush seen while waiting squashes the result, not the access.
        if (i_flush) kill_q <= 1'b1;
        if (i_dmem_ack) o_dmem_req <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid         <= 1'b0;
      o_ALU_Data      <= '0;
      o_Mem_Data      <= '0;
      o_ctrl_MemToReg <= 1'b0;
      o_ctrl_RegWrite <= 1'b0;
      o_Rd            <= '0;
    end else begin
      o_valid         <= 1'b0;
      o_ALU_Data      <= '0;
      o_Mem_Data      <= '0;
      o_ctrl_MemToReg <= 1'b0;
      o_ctrl_RegWrite <= 1'b0;
      o_Rd            <= '0;
      if ((state == IDLE && live && !is_mem) ||
          (state == BUSY && i_dmem_ack && !kill_q && live)) begin
        o_valid         <= 1'b1;
        o_ALU_Data      <= i_ALU_Result;
        o_Mem_Data      <= (state == BUSY) ? ld_data : '0;
        o_ctrl_MemToReg <= i_ctrl_MemToReg;
        o_ctrl_RegWrite <= i_ctrl_RegWrite;
        o_Rd            <= i_Rd;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed, table-driven bench for mem_stage: load/store vectors plus fault, flush and reset sequences.
module tb_mem_stage;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid, i_flush;
  logic [31:0] i_ALU_Result, i_Store_Data;
  logic [2:0]  i_Funct3;
  logic        i_ctrl_MemRead, i_ctrl_MemWrite, i_ctrl_MemToReg, i_ctrl_RegWrite;
  logic [4:0]  i_Rd;
  logic        o_stall, o_mem_fault, o_dmem_req, o_dmem_we;
  logic [31:0] o_dmem_addr, o_dmem_wdata;
  logic [3:0]  o_dmem_be;
  logic        i_dmem_ack;
  logic [31:0] i_dmem_rdata;
  logic        o_valid;
  logic [31:0] o_ALU_Data, o_Mem_Data;
  logic        o_ctrl_MemToReg, o_ctrl_RegWrite;
  logic [4:0]  o_Rd;

  int checks = 0;
  int errors = 0;

  mem_stage dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_flush(i_flush),
    .i_ALU_Result(i_ALU_Result), .i_Store_Data(i_Store_Data), .i_Funct3(i_Funct3),
    .i_ctrl_MemRead(i_ctrl_MemRead), .i_ctrl_MemWrite(i_ctrl_MemWrite),
    .i_ctrl_MemToReg(i_ctrl_MemToReg), .i_ctrl_RegWrite(i_ctrl_RegWrite), .i_Rd(i_Rd),
    .o_stall(o_stall), .o_mem_fault(o_mem_fault), .o_dmem_req(o_dmem_req),
    .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata),
    .o_dmem_be(o_dmem_be), .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
    .o_valid(o_valid), .o_ALU_Data(o_ALU_Data), .o_Mem_Data(o_Mem_Data),
    .o_ctrl_MemToReg(o_ctrl_MemToReg), .o_ctrl_RegWrite(o_ctrl_RegWrite), .o_Rd(o_Rd)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, sdata, rdata;
    int          d;
    logic [3:0]  be;
    logic [31:0] wdata, mdata;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rdst);
    i_valid = v; i_flush = 1'b0;
    i_ctrl_MemRead = rd; i_ctrl_MemWrite = wr;
    i_ctrl_MemToReg = rd; i_ctrl_RegWrite = v & ~wr;
    i_Funct3 = f3; i_ALU_Result = alu; i_Store_Data = sd; i_Rd = rdst;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
  endtask

  task automatic alu_op(input logic [31:0] val, input logic [4:0] rdst);
    @(posedge i_clk); #1;
    drive(1'b1, 1'b0, 1'b0, 3'd0, val, 32'd0, rdst);
    @(negedge i_clk);
    chk("alu_stall", {31'd0, o_stall}, 32'd0);
    @(posedge i_clk); #1;
    idle_in();
    @(negedge i_clk);
    chk("alu_valid", {31'd0, o_valid}, 32'd1);
    chk("alu_data", o_ALU_Data, val);
    chk("alu_rd", {27'd0, o_Rd}, {27'd0, rdst});
    chk("alu_rw", {31'd0, o_ctrl_RegWrite}, 32'd1);
    chk("alu_mdata", o_Mem_Data, 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int stalls;
    stalls = 0;
    @(posedge i_clk); #1;
    drive(1'b1, ~v.we, v.we, v.f3, v.addr, v.sdata, 5'd7);
    @(negedge i_clk);
    if (o_stall) stalls++;
    chk("launch_req", {31'd0, o_dmem_req}, 32'd0);
    @(posedge i_clk); #1;
    for (int i = 0; i < v.d; i++) begin
      @(negedge i_clk);
      if (o_stall) stalls++;
      chk("wait_req", {31'd0, o_dmem_req}, 32'd1);
      @(posedge i_clk); #1;
    end
    i_dmem_ack = 1'b1; i_dmem_rdata = v.rdata;
    @(negedge i_clk);
    chk("ack_stall", {31'd0, o_stall}, 32'd0);
    chk("stall_cycles", stalls, 1 + v.d);
    chk("req", {31'd0, o_dmem_req}, 32'd1);
    chk("we", {31'd0, o_dmem_we}, {31'd0, v.we});
    chk("addr", o_dmem_addr, {v.addr[31:2], 2'b00});
    if (v.we) begin
      chk("be", {28'd0, o_dmem_be}, {28'd0, v.be});
      chk("wdata", o_dmem_wdata, v.wdata);
    end
    @(posedge i_clk); #1;
    i_dmem_ack = 1'b0;
    idle_in();
    @(negedge i_clk);
    chk("wb_valid", {31'd0, o_valid}, 32'd1);
    chk("wb_mdata", o_Mem_Data, v.mdata);
    chk("wb_alu", o_ALU_Data, v.addr);
    chk("wb_rw", {31'd0, o_ctrl_RegWrite}, {31'd0, ~v.we});
    chk("wb_rd", {27'd0, o_Rd}, 32'd7);
    chk("req_drop", {31'd0, o_dmem_req}, 32'd0);
  endtask

  task automatic fault_case(input logic wr, input logic [2:0] f3, input logic [31:0] addr);
    @(posedge i_clk); #1;
    drive(1'b1, ~wr, wr, f3, addr, 32'h1111_2222, 5'd9);
    @(negedge i_clk);
    chk("flt_stall", {31'd0, o_stall}, 32'd0);
    @(posedge i_clk); #1;
    idle_in();
    @(negedge i_clk);
    chk("flt_pulse", {31'd0, o_mem_fault}, 32'd1);
    chk("flt_req", {31'd0, o_dmem_req}, 32'd0);
    chk("flt_valid", {31'd0, o_valid}, 32'd0);
    chk("flt_rw", {31'd0, o_ctrl_RegWrite}, 32'd0);
    @(negedge i_clk);
    chk("flt_end", {31'd0, o_mem_fault}, 32'd0);
  endtask

  initial begin
    //        we    f3    addr          sdata         rdata         d  be       wdata         mdata
    vt[0] = '{1'b0, 3'd0, 32'h0000_0103, 32'h0,        32'h80FF_FF7F, 2, 4'b0000, 32'h0,        32'hFFFF_FF80};
    vt[1] = '{1'b0, 3'd4, 32'h0000_0103, 32'h0,        32'h80FF_FF7F, 0, 4'b0000, 32'h0,        32'h0000_0080};
    vt[2] = '{1'b1, 3'd1, 32'h0000_0202, 32'hAAAA_BEEF, 32'h0,        0, 4'b1100, 32'hBEEF_BEEF, 32'h0};
    vt[3] = '{1'b1, 3'd0, 32'h0000_0401, 32'h1234_5678, 32'h0,        1, 4'b0010, 32'h7878_7878, 32'h0};
    vt[4] = '{1'b1, 3'd2, 32'h0000_0500, 32'hCAFE_F00D, 32'h0,        0, 4'b1111, 32'hCAFE_F00D, 32'h0};
    vt[5] = '{1'b0, 3'd1, 32'h0000_0602, 32'h0,        32'h8001_1234, 1, 4'b0000, 32'h0,        32'hFFFF_8001};
    vt[6] = '{1'b0, 3'd5, 32'h0000_0600, 32'h0,        32'h8001_9234, 0, 4'b0000, 32'h0,        32'h0000_9234};
    vt[7] = '{1'b0, 3'd2, 32'h0000_0700, 32'h0,        32'hDEAD_BEEF, 0, 4'b0000, 32'h0,        32'hDEAD_BEEF};
    vt[8] = '{1'b0, 3'd0, 32'h0000_0100, 32'h0,        32'h80FF_FF7F, 0, 4'b0000, 32'h0,        32'h0000_007F};

    i_rst_n = 1'b0; i_dmem_ack = 1'b0; i_dmem_rdata = '0;
    idle_in();
    @(negedge i_clk);
    chk("rst_req", {31'd0, o_dmem_req}, 32'd0);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_stall", {31'd0, o_stall}, 32'd0);
    chk("rst_fault", {31'd0, o_mem_fault}, 32'd0);
    i_rst_n = 1'b1;

    alu_op(32'h0000_1234, 5'd5);
    for (int k = 0; k < 9; k++) run_vec(vt[k]);

    fault_case(1'b0, 3'd2, 32'h0000_0301);
    fault_case(1'b1, 3'd1, 32'h0000_0203);
    fault_case(1'b1, 3'd4, 32'h0000_0200);

    // Flush while waiting: access completes, result is squashed.
    @(posedge i_clk); #1;
    drive(1'b1, 1'b1, 1'b0, 3'd2, 32'h0000_0800, 32'd0, 5'd3);
    @(posedge i_clk); #1;
    i_flush = 1'b1;
    @(negedge i_clk);
    chk("fl_req0", {31'd0, o_dmem_req}, 32'd1);
    @(posedge i_clk); #1;
    i_flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge i_clk);
      chk("fl_req_held", {31'd0, o_dmem_req}, 32'd1);
      chk("fl_stall", {31'd0, o_stall}, 32'd1);
      @(posedge i_clk); #1;
    end
    i_dmem_ack = 1'b1; i_dmem_rdata = 32'h5555_AAAA;
    @(posedge i_clk); #1;
    i_dmem_ack = 1'b0;
    idle_in();
    @(negedge i_clk);
    chk("fl_valid", {31'd0, o_valid}, 32'd0);
    chk("fl_rw", {31'd0, o_ctrl_RegWrite}, 32'd0);
    chk("fl_req_drop", {31'd0, o_dmem_req}, 32'd0);
    alu_op(32'h0000_4321, 5'd12);

    // Reset in the middle of a transaction.
    @(posedge i_clk); #1;
    drive(1'b1, 1'b1, 1'b0, 3'd2, 32'h0000_0900, 32'd0, 5'd4);
    @(posedge i_clk); #1;
    idle_in();
    @(negedge i_clk);
    chk("mr_req_busy", {31'd0, o_dmem_req}, 32'd1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("mr_req", {31'd0, o_dmem_req}, 32'd0);
    chk("mr_valid", {31'd0, o_valid}, 32'd0);
    chk("mr_addr", o_dmem_addr, 32'd0);
    chk("mr_rd", {27'd0, o_Rd}, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    alu_op(32'h0000_00AB, 5'd6);
    @(negedge i_clk);
    chk("mr_idle_req", {31'd0, o_dmem_req}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
